mux_rr_sel_arbiter: RTL and testbench



---
 rtl/mux_rr_sel_arbiter.sv | 98 +++++++++
 tb/tb_mux_rr_sel_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter that drives the 2-bit select of a 4:1 data mux.
// A winner holds the select for a burst of BEATS accepted beats. The arbiter
// then spends one IDLE cycle and rotates priority past the source it just served.
// All outputs are registered, so req and out_ready never reach an output
// combinationally.
module mux_rr_sel_arbiter #(
    parameter int BEATS = 4,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic          out_ready,
    output logic [1:0]    sel,
    output logic [3:0]    gnt,
    output logic          out_valid,
    output logic [CW-1:0] beat_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value at which one more accepted beat ends the burst.
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t     state;
    logic [1:0] last;

    // First requesting source searching upward from ptr+1 with modulo-4 wrap.
    // The search is only used when r is nonzero, so the ptr fallback is never
    // selected in practice.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Binary source index to one-hot grant vector.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Arbitration FSM. It owns the state, the priority pointer and every output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd3;
            sel       <= 2'd0;
            gnt       <= 4'b0000;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // sel keeps its last value while nothing is granted.
                    if (req != 4'b0000) begin
                        sel       <= rr_pick(req, last);
                        gnt       <= onehot(rr_pick(req, last));
                        out_valid <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // The grant is committed: req is ignored until the next IDLE.
                    if (out_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            last      <= sel;
                            beat_cnt  <= '0;
                            gnt       <= 4'b0000;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 4'b0000;
                    out_valid <= 1'b0;
                    beat_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Directed bench for mux_rr_sel_arbiter with BEATS=4.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_mux_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] beat_cnt;

    int total;
    int bad;

    mux_rr_sel_arbiter #(.BEATS(4), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Check one full 4-beat grant on source s with out_ready high.
    // The task ends in the IDLE cycle that follows the burst, without advancing.
    task automatic burst(input logic [1:0] s);
        for (int b = 0; b < 4; b++) begin
            check_val("burst_valid", 32'(out_valid), 32'd1);
            check_val("burst_sel",   32'(sel),       32'(s));
            check_val("burst_gnt",   32'(gnt),       32'(1) << s);
            check_val("burst_cnt",   32'(beat_cnt),  32'(b));
            tick();
        end
        check_val("idle_valid", 32'(out_valid), 32'd0);
        check_val("idle_gnt",   32'(gnt),       32'd0);
        check_val("idle_sel",   32'(sel),       32'(s));
        check_val("idle_cnt",   32'(beat_cnt),  32'd0);
    endtask

    logic pat [7];
    int   exp_cnt [6];

    initial begin
        total     = 0;
        bad       = 0;
        pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt   = '{1, 1, 1, 2, 3, 3};
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;

        // Reset held for two edges with all requests active.
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("rst_sel",   32'(sel),       32'd0);
            check_val("rst_gnt",   32'(gnt),       32'd0);
            check_val("rst_valid", 32'(out_valid), 32'd0);
            check_val("rst_cnt",   32'(beat_cnt),  32'd0);
        end
        rst_n = 1'b1;
        tick();
        check_val("first_gnt", 32'(gnt), 32'b0001);

        // Full rotation 0,1,2,3,0.
        for (int g = 0; g < 5; g++) begin
            burst(2'(g % 4));
            tick();
        end
        // The loop ends in GRANT on source 1; return to reset for a clean pointer.
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;

        // Sparse requests 0101 give sources 0,2,0,2. While source 2 holds the
        // grant, req switches to 1000 so that source 3 wins twice.
        req = 4'b0101;
        tick();
        burst(2'd0); tick();
        burst(2'd2); tick();
        burst(2'd0); tick();
        req = 4'b1000;
        burst(2'd2); tick();
        burst(2'd3); tick();
        burst(2'd3);

        // Backpressure on source 1 (last = 3, so source 1 wins outright).
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            check_val("bp_sel",   32'(sel),       32'd1);
            check_val("bp_valid", 32'(out_valid), 32'd1);
            out_ready = pat[i];
            tick();
            if (i < 6) check_val("bp_cnt", 32'(beat_cnt), 32'(exp_cnt[i]));
        end
        check_val("bp_idle_valid", 32'(out_valid), 32'd0);
        check_val("bp_idle_cnt",   32'(beat_cnt),  32'd0);
        out_ready = 1'b1;

        // Source 2 drops its request after one beat, but the burst completes.
        req = 4'b0100;
        tick();
        check_val("drop_gnt0", 32'(gnt), 32'b0100);
        tick();
        req = 4'b0000;
        for (int b = 1; b < 4; b++) begin
            check_val("drop_gnt", 32'(gnt),      32'b0100);
            check_val("drop_cnt", 32'(beat_cnt), 32'(b));
            tick();
        end
        check_val("drop_end_valid", 32'(out_valid), 32'd0);

        // Reset during the 2nd beat of a source 3 grant.
        req = 4'b1000;
        tick();
        check_val("mid_sel", 32'(sel), 32'd3);
        tick();
        check_val("mid_cnt", 32'(beat_cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        check_val("mrst_sel",   32'(sel),       32'd0);
        check_val("mrst_gnt",   32'(gnt),       32'd0);
        check_val("mrst_valid", 32'(out_valid), 32'd0);
        check_val("mrst_cnt",   32'(beat_cnt),  32'd0);
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        check_val("post_rst_sel", 32'(sel), 32'd1);
        check_val("post_rst_gnt", 32'(gnt), 32'b0010);
        burst(2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
